// File: rtl/spi_slave_regfile.sv
// -----------------------------------------------------------------------------
// spi_slave_regfile
//
// SPI target with an 8-bit register file. It runs entirely on the system clock
// and oversamples sclk, ss_n and mosi through synchronizer chains. It can be
// used as a bench model for a SPI controller or as an on-chip loopback target.
//
// Frame format (both bytes LSB first):
//   address byte : bit7 = 1 write / 0 read, bits[6:0] = register index.
//                  Index bits above ADDR_W-1 must be zero, otherwise the
//                  frame is illegal.
//   data byte    : write data (write) or register contents on miso (read).
//
// Parameters:
//   ADDR_W      register index width (depth = 2**ADDR_W, ADDR_W <= 7)
//   RST_VAL     reset value of every register
//   SYNC_STAGES synchronizer depth on sclk/ss_n/mosi (minimum 2)
//
// Ports:
//   pclk_i      system clock, at least 4x the sclk frequency
//   prst_i      asynchronous active-high reset
//   sclk_i      SPI clock
//   ss_n_i      active-low slave select
//   mosi_i      serial data in
//   miso_o      serial read data
//   miso_oe_o   high while this target drives miso
//   wr_evt_o    one-cycle pulse when a register write commits
//   wr_addr_o   index of the committed write (valid with wr_evt_o)
//   wr_data_o   data of the committed write (valid with wr_evt_o)
//   frame_err_o one-cycle pulse on an aborted or illegal frame
//
// Build option:
//   SPI_SLV_AUTOINC_EN  when defined, a frame may carry several data bytes;
//                       the register index advances (wrapping) after each
//                       completed byte while ss_n stays low. When undefined,
//                       bytes after the first data byte are ignored.
// -----------------------------------------------------------------------------
module spi_slave_regfile #(
  parameter int         ADDR_W      = 4,
  parameter logic [7:0] RST_VAL     = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              pclk_i,
  input  logic              prst_i,
  input  logic              sclk_i,
  input  logic              ss_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic              wr_evt_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              frame_err_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Input synchronizers plus one delayed copy for edge detection.
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ssn_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_q;
  logic                   r_ssn_q;

  // FSM and frame bookkeeping.
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2:0]             r_cnt;
  logic [6:0]             r_sh_in;
  logic                   r_wr;
  logic                   r_illegal;
  logic [ADDR_W-1:0]      r_idx;

  // Read shifter: r_miso carries the current bit, r_shift the bits still to go.
  logic [6:0]             r_shift;
  logic                   r_miso;
  logic                   r_oe;

  // Register file and registered outputs.
  logic [7:0]             r_rf [DEPTH];
  logic                   r_wr_evt;
  logic [ADDR_W-1:0]      r_wr_addr;
  logic [7:0]             r_wr_data;
  logic                   r_frame_err;

`ifdef SPI_SLV_AUTOINC_EN
  logic                   r_byte_done;
  logic [ADDR_W-1:0]      w_idx_inc;
`endif

  // Conditioned inputs and decoded edges.
  logic                   w_sclk_s;
  logic                   w_ssn_s;
  logic                   w_mosi_s;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_ss_fall;
  logic                   w_ss_rise;

  // Byte being completed on this sclk rise (bit 7 is the live mosi sample).
  logic [7:0]             w_in_byte;
  logic [ADDR_W-1:0]      w_dec_idx;
  logic                   w_dec_illegal;

  // Per-cycle decisions from the output process.
  logic                   w_addr_done;
  logic                   w_data_done;
  logic                   w_burst_end;
  logic                   w_abort;
  logic                   w_commit;
  logic                   w_err;
  logic                   w_load;
  logic [ADDR_W-1:0]      w_load_idx;
  logic                   w_load_ill;
  logic [7:0]             w_load_val;
  logic                   w_shift;
  logic                   w_oe_nxt;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      r_sclk_sync <= '0;
      r_ssn_sync  <= '1;
      r_mosi_sync <= '0;
      r_sclk_q    <= 1'b0;
      r_ssn_q     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
      r_ssn_sync  <= {r_ssn_sync[SYNC_STAGES-2:0], ss_n_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
      r_sclk_q    <= w_sclk_s;
      r_ssn_q     <= w_ssn_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ssn_s     = r_ssn_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk_s & ~r_sclk_q;
  assign w_sclk_fall = ~w_sclk_s &  r_sclk_q;
  assign w_ss_fall   = ~w_ssn_s  &  r_ssn_q;
  assign w_ss_rise   =  w_ssn_s  & ~r_ssn_q;

  assign w_in_byte     = {w_mosi_s, r_sh_in};
  assign w_dec_idx     = w_in_byte[ADDR_W-1:0];
  // Any set index bit above the implemented range makes the frame illegal.
  assign w_dec_illegal = |(w_in_byte[6:0] >> ADDR_W);

`ifdef SPI_SLV_AUTOINC_EN
  assign w_idx_inc = r_idx + 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ss_fall) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        // A deselect during the address byte always aborts, even on its 8th rise.
        if (w_ss_rise) begin
          w_state_nxt = S_IDLE;
        end else if (w_sclk_rise && (r_cnt == 3'd7)) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        // The 8th data rise completes the byte even if ss_n rises with it.
        if (w_sclk_rise && (r_cnt == 3'd7)) begin
          if (w_ss_rise) begin
            w_state_nxt = S_IDLE;
          end else begin
`ifdef SPI_SLV_AUTOINC_EN
            w_state_nxt = S_DATA;
`else
            w_state_nxt = S_DONE;
`endif
          end
        end else if (w_ss_rise) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        if (w_ss_rise) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    w_addr_done = (r_state == S_ADDR) && w_sclk_rise && (r_cnt == 3'd7) && !w_ss_rise;
    w_data_done = (r_state == S_DATA) && w_sclk_rise && (r_cnt == 3'd7);

`ifdef SPI_SLV_AUTOINC_EN
    // Deselect between bytes of a burst is the normal end of the frame.
    w_burst_end = (r_state == S_DATA) && (r_cnt == 3'd0) && r_byte_done;
`else
    w_burst_end = 1'b0;
`endif

    w_abort  = w_ss_rise &&
               ((r_state == S_ADDR) ||
                ((r_state == S_DATA) && !w_data_done && !w_burst_end));
    w_commit = w_data_done && r_wr && !r_illegal;
    w_err    = w_abort || (w_data_done && r_illegal);

    w_load     = 1'b0;
    w_load_idx = w_dec_idx;
    w_load_ill = w_dec_illegal;
    if (w_addr_done && !w_in_byte[7]) begin
      w_load = 1'b1;
    end
`ifdef SPI_SLV_AUTOINC_EN
    // Burst read: preload the following register at the end of each byte.
    if (w_data_done && !r_wr && !w_ss_rise) begin
      w_load     = 1'b1;
      w_load_idx = w_idx_inc;
      w_load_ill = r_illegal;
    end
`endif

    // The fall right after the 8th rise (cnt back at 0) must not advance,
    // bit0 was already presented at the load.
    w_shift  = (r_state == S_DATA) && w_sclk_fall && (r_cnt != 3'd0) && !r_wr;

    // miso is owned only while a read data byte is in progress.
    w_oe_nxt = (w_state_nxt == S_DATA) &&
               !((r_state == S_ADDR) ? w_in_byte[7] : r_wr);
  end

  assign w_load_val = w_load_ill ? 8'h00 : r_rf[w_load_idx];

  // ---------------------------------------------------------------------------
  // Frame datapath, register file and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      r_cnt       <= 3'd0;
      r_sh_in     <= 7'd0;
      r_wr        <= 1'b0;
      r_illegal   <= 1'b0;
      r_idx       <= '0;
      r_shift     <= 7'd0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_wr_evt    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'h00;
      r_frame_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rf[i] <= RST_VAL;
      end
`ifdef SPI_SLV_AUTOINC_EN
      r_byte_done <= 1'b0;
`endif
    end else begin
      // Bit counter wraps 7 -> 0 at the end of every byte by itself.
      if (r_state == S_IDLE) begin
        r_cnt <= 3'd0;
      end else if (((r_state == S_ADDR) || (r_state == S_DATA)) && w_sclk_rise) begin
        r_cnt   <= r_cnt + 3'd1;
        r_sh_in <= w_in_byte[7:1];
      end

      if (w_addr_done) begin
        r_wr      <= w_in_byte[7];
        r_idx     <= w_dec_idx;
        r_illegal <= w_dec_illegal;
      end

`ifdef SPI_SLV_AUTOINC_EN
      if (r_state == S_IDLE) begin
        r_byte_done <= 1'b0;
      end else if (w_data_done && !w_ss_rise) begin
        r_byte_done <= 1'b1;
        r_idx       <= w_idx_inc;
      end
`endif

      if (w_load) begin
        r_shift <= w_load_val[7:1];
        r_miso  <= w_load_val[0];
      end else if (w_shift) begin
        r_shift <= {1'b0, r_shift[6:1]};
        r_miso  <= r_shift[0];
      end
      if (!w_oe_nxt) begin
        r_miso <= 1'b0;
      end
      r_oe <= w_oe_nxt;

      r_wr_evt    <= w_commit;
      r_frame_err <= w_err;
      if (w_commit) begin
        r_rf[r_idx] <= w_in_byte;
        r_wr_addr   <= r_idx;
        r_wr_data   <= w_in_byte;
      end
    end
  end

  assign miso_o      = r_miso;
  assign miso_oe_o   = r_oe;
  assign wr_evt_o    = r_wr_evt;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_regfile
//
// Self-checking bench for spi_slave_regfile (default parameters, ADDR_W = 4).
// Acts as a mode-0 SPI controller: mosi changes while sclk is low, both sides
// use the sclk rise; miso is sampled just before each rise.
// Follows SPI_SLV_AUTOINC_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_spi_slave_regfile;

  localparam int HALF = 5;  // pclk cycles per sclk half period

`ifdef SPI_SLV_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       pclk;
  logic       prst;
  logic       sclk;
  logic       ss_n;
  logic       mosi;
  logic       miso_o;
  logic       miso_oe_o;
  logic       wr_evt_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       frame_err_o;

  spi_slave_regfile dut (
    .pclk_i      (pclk),
    .prst_i      (prst),
    .sclk_i      (sclk),
    .ss_n_i      (ss_n),
    .mosi_i      (mosi),
    .miso_o      (miso_o),
    .miso_oe_o   (miso_oe_o),
    .wr_evt_o    (wr_evt_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .frame_err_o (frame_err_o)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  // Observed write events {addr, data} and frame-error pulse count.
  logic [11:0] ev_q[$];
  int          err_pulses = 0;

  always @(negedge pclk) begin
    if (wr_evt_o) ev_q.push_back({wr_addr_o, wr_data_o});
    if (frame_err_o) err_pulses++;
  end

  // Reference register file.
  logic [7:0] model_rf [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic spi_bits(input logic [31:0] tx, input int nbits,
                          output logic [31:0] rx, output logic [31:0] oem);
    rx  = '0;
    oem = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[i];
      wait_cyc(HALF);
      rx[i]  = miso_o;
      oem[i] = miso_oe_o;
      sclk   = 1'b1;
      wait_cyc(HALF);
      sclk   = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [31:0] tx, input int nbits,
                          output logic [31:0] rx, output logic [31:0] oem);
    @(negedge pclk);
    ss_n = 1'b0;
    wait_cyc(HALF);
    spi_bits(tx, nbits, rx, oem);
    wait_cyc(HALF);
    ss_n = 1'b1;
    mosi = 1'b0;
    wait_cyc(3 * HALF);
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] d, input int nbits,
                          output logic [15:0] rx, output logic [15:0] oem,
                          output int nevt, output int nerr);
    logic [31:0] rx32;
    logic [31:0] oe32;
    int          e0;
    ev_q.delete();
    e0 = err_pulses;
    spi_xfer({16'h0000, d, a}, nbits, rx32, oe32);
    rx   = rx32[15:0];
    oem  = oe32[15:0];
    nevt = ev_q.size();
    nerr = err_pulses - e0;
  endtask

  // Frame semantics at transaction level: an incomplete frame is an error with
  // no effect; an out-of-range index is an error; otherwise write or read.
  task automatic model_frame(input logic [7:0] a, input logic [7:0] d, input int nbits,
                             output int m_evt, output int m_err,
                             output bit m_rd, output logic [7:0] m_rdv);
    m_evt = 0;
    m_err = 0;
    m_rd  = 1'b0;
    m_rdv = 8'h00;
    if (nbits < 16) begin
      m_err = 1;
    end else if (a[6:4] != 3'd0) begin
      m_err = 1;
      m_rd  = !a[7];
    end else if (a[7]) begin
      model_rf[a[3:0]] = d;
      m_evt = 1;
    end else begin
      m_rd  = 1'b1;
      m_rdv = model_rf[a[3:0]];
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    bit         is_rd;
    int         exp_evt;
    logic [3:0] exp_idx;
    logic [7:0] exp_wd;
    int         exp_err;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vec [8];

  initial begin
    logic [15:0] rx;
    logic [15:0] oem;
    logic [31:0] rx32;
    logic [31:0] oe32;
    int          nevt;
    int          nerr;
    int          e0;
    int          m_evt;
    int          m_err;
    bit          m_rd;
    logic [7:0]  m_rdv;
    logic [7:0]  a;
    logic [7:0]  d;
    int          nb;

    vec[0] = '{8'h83, 8'h46, 1'b0, 1, 4'd3, 8'h46, 0, 8'h00};  // write reg3
    vec[1] = '{8'h03, 8'h00, 1'b1, 0, 4'd0, 8'h00, 0, 8'h46};  // read reg3
    vec[2] = '{8'hD3, 8'h53, 1'b0, 0, 4'd0, 8'h00, 1, 8'h00};  // illegal write
    vec[3] = '{8'h03, 8'hFF, 1'b1, 0, 4'd0, 8'h00, 0, 8'h46};  // reg3 unchanged
    vec[4] = '{8'h53, 8'h00, 1'b1, 0, 4'd0, 8'h00, 1, 8'h00};  // illegal read
    vec[5] = '{8'h81, 8'hA5, 1'b0, 1, 4'd1, 8'hA5, 0, 8'h00};  // write reg1
    vec[6] = '{8'h01, 8'h00, 1'b1, 0, 4'd0, 8'h00, 0, 8'hA5};  // read reg1
    vec[7] = '{8'h0F, 8'h00, 1'b1, 0, 4'd0, 8'h00, 0, 8'h00};  // untouched reg

    for (int i = 0; i < 16; i++) model_rf[i] = 8'h00;

    prst = 1'b1;
    sclk = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    wait_cyc(3);
    chk("reset_outputs", {miso_o, miso_oe_o, wr_evt_o, wr_addr_o, wr_data_o, frame_err_o}, 32'h0);
    prst = 1'b0;
    wait_cyc(5);

    // Directed frames from the table.
    for (int k = 0; k < 8; k++) begin
      do_frame(vec[k].addr, vec[k].data, 16, rx, oem, nevt, nerr);
      chk($sformatf("tbl%0d_nevt", k), nevt, vec[k].exp_evt);
      if (nevt > 0) chk($sformatf("tbl%0d_evt", k), {20'h0, ev_q[0]}, {20'h0, vec[k].exp_idx, vec[k].exp_wd});
      chk($sformatf("tbl%0d_err", k), nerr, vec[k].exp_err);
      if (vec[k].is_rd) begin
        chk($sformatf("tbl%0d_rd", k), rx[15:8], vec[k].exp_rd);
        if (vec[k].exp_err == 0) chk($sformatf("tbl%0d_oe_mask", k), oem, 16'hFF00);
      end else begin
        chk($sformatf("tbl%0d_oe_mask", k), oem, 16'h0000);
      end
      chk($sformatf("tbl%0d_oe_after", k), miso_oe_o, 1'b0);
      model_frame(vec[k].addr, vec[k].data, 16, m_evt, m_err, m_rd, m_rdv);
    end

    // Abort after 5 address bits, then a legal write must still work.
    do_frame(8'h81, 8'h00, 5, rx, oem, nevt, nerr);
    chk("abort_err", nerr, 1);
    chk("abort_nevt", nevt, 0);
    do_frame(8'h81, 8'hA5, 16, rx, oem, nevt, nerr);
    chk("post_abort_nevt", nevt, 1);
    if (nevt > 0) chk("post_abort_evt", ev_q[0], {4'd1, 8'hA5});
    chk("post_abort_err", nerr, 0);

    // Three-byte frame: burst write with auto-increment, else extra byte ignored.
    ev_q.delete();
    e0 = err_pulses;
    spi_xfer({8'h00, 8'h22, 8'h11, 8'h8F}, 24, rx32, oe32);
    chk("burst_nevt", ev_q.size(), AUTOINC ? 2 : 1);
    if (ev_q.size() > 0) chk("burst_evt0", ev_q[0], {4'hF, 8'h11});
    if (ev_q.size() > 1) chk("burst_evt1", ev_q[1], {4'h0, 8'h22});
    chk("burst_err", err_pulses - e0, 0);
    model_rf[15] = 8'h11;
    model_rf[0]  = AUTOINC ? 8'h22 : model_rf[0];
    do_frame(8'h0F, 8'h00, 16, rx, oem, nevt, nerr);
    chk("burst_rd15", rx[15:8], 8'h11);
    do_frame(8'h00, 8'h00, 16, rx, oem, nevt, nerr);
    chk("burst_rd0", rx[15:8], AUTOINC ? 8'h22 : 8'h00);

    // Reset in the middle of the data byte of a write to register 2.
    do_frame(8'h82, 8'h77, 16, rx, oem, nevt, nerr);
    chk("pre_reset_wr", nevt, 1);
    @(negedge pclk);
    ss_n = 1'b0;
    wait_cyc(HALF);
    spi_bits({16'h0000, 8'h3C, 8'h82}, 12, rx32, oe32);
    prst = 1'b1;
    #1;
    chk("midframe_reset_outputs",
        {miso_o, miso_oe_o, wr_evt_o, wr_addr_o, wr_data_o, frame_err_o}, 32'h0);
    wait_cyc(2);
    ss_n = 1'b1;
    mosi = 1'b0;
    wait_cyc(3);
    prst = 1'b0;
    wait_cyc(5);
    for (int i = 0; i < 16; i++) model_rf[i] = 8'h00;
    do_frame(8'h02, 8'h00, 16, rx, oem, nevt, nerr);
    chk("reset_rd2", rx[15:8], 8'h00);
    do_frame(8'h03, 8'h00, 16, rx, oem, nevt, nerr);
    chk("reset_rd3", rx[15:8], 8'h00);

    // Random frames against the reference model.
    for (int n = 0; n < 48; n++) begin
      a[7]   = 1'($urandom_range(0, 1));
      a[3:0] = 4'($urandom_range(0, 15));
      a[6:4] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      d      = 8'($urandom_range(0, 255));
      nb     = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : 16;
      do_frame(a, d, nb, rx, oem, nevt, nerr);
      model_frame(a, d, nb, m_evt, m_err, m_rd, m_rdv);
      chk($sformatf("rnd%0d_a%0h_nevt", n, a), nevt, m_evt);
      if (nevt > 0 && m_evt > 0) chk($sformatf("rnd%0d_evt", n), ev_q[0], {a[3:0], d});
      chk($sformatf("rnd%0d_a%0h_err", n, a), nerr, m_err);
      if (m_rd) chk($sformatf("rnd%0d_a%0h_rd", n, a), rx[15:8], m_rdv);
      if (m_rd && m_err == 0) chk($sformatf("rnd%0d_oe_mask", n), oem, 16'hFF00);
      chk($sformatf("rnd%0d_oe_after", n), miso_oe_o, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- Downstream SPI target for spi_controller: consumes sclk/ss/mosi frames from one slave-select line and drives miso.
- Contains an 8-bit register file that the frames write and read.
- Runs entirely on the system clock. It oversamples sclk, ss_n and mosi, so it is used both as a bench model and as an on-chip loopback target.
- Frame format: one address byte, then one data byte, both LSB first. Address bit7 = 1 means write, 0 means read; address bits[6:0] select the register.

Parameters:
- ADDR_W, 4, register index width; depth = 2**ADDR_W.
- RST_VAL, 8'h00, reset value of every register.
- SYNC_STAGES, 2, synchronizer depth on sclk_i, ss_n_i and mosi_i (minimum 2).

Ports:
- pclk_i  input  1  system clock; must be at least 4x the sclk_i frequency.
- prst_i  input  1  asynchronous active-high reset.
- sclk_i  input  1  SPI clock from the controller (sclk_o of spi_controller).
- ss_n_i  input  1  active-low slave select (one bit of the controller ss bus).
- mosi_i  input  1  serial data from the controller.
- miso_o  output  1  serial read data.
- miso_oe_o  output  1  high while this target owns miso.
- wr_evt_o  output  1  one-cycle pulse when a register write commits.
- wr_addr_o  output  ADDR_W  index of the committed write; valid with wr_evt_o.
- wr_data_o  output  8  data of the committed write; valid with wr_evt_o.
- frame_err_o  output  1  one-cycle pulse on an aborted or illegal frame.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: miso_o=0, miso_oe_o=0, wr_evt_o=0, wr_addr_o=0, wr_data_o=0, frame_err_o=0.
  - Internal state: all registers = RST_VAL, FSM = IDLE, bit counter = 0, synchronizers = idle level (sclk 0, ss_n 1).
- Input conditioning: sclk_i, ss_n_i and mosi_i pass through SYNC_STAGES flops. A rise or fall is one synchronized level change seen between consecutive pclk cycles. mosi is sampled from its synchronized copy on the same pclk cycle the sclk rise is detected.
- IDLE:
  - ss_n falling -> ADDR, bit counter cleared.
  - sclk edges are ignored while ss_n = 1.
- ADDR: each sclk rise shifts mosi into addr[cnt], then cnt++. After the 8th rise:
  - Decode: wr = addr[7]; idx = addr[ADDR_W-1:0]; illegal = (addr[6:ADDR_W] != 0).
  - Read, legal: load shift register with reg[idx]; miso_o = reg[idx][0], miso_oe_o = 1, both on the pclk cycle after the 8th rise.
  - Read, illegal: shift register loaded with 8'h00.
  - Either case -> DATA, cnt = 0.
- DATA, write: each sclk rise shifts mosi into data[cnt]. After the 8th rise:
  - Legal: the register updates and wr_evt_o pulses on the next pclk, with wr_addr_o = idx and wr_data_o = data.
  - Illegal: no update, no wr_evt_o; frame_err_o pulses instead.
  - Either case -> DONE.
- DATA, read:
  - Each sclk fall, except the fall following the 8th rise, advances miso_o to the next bit (bit1..bit7).
  - After the 8th rise -> DONE.
  - An illegal read pulses frame_err_o at the 8th rise.
- DONE:
  - Further sclk edges are ignored.
  - miso_oe_o drops on entry.
  - ss_n rising -> IDLE.
- Abort: ss_n rising in ADDR or DATA -> IDLE with no register update. frame_err_o pulses once and miso_oe_o drops on that same cycle.
- Simultaneous events:
  - ss_n rising detected on the same pclk as the 8th data rise: the write commits and is not flagged; ss_n rising takes priority only for an incomplete count.
  - An sclk rise and an sclk fall cannot coincide after synchronization.
- Register file: written only by completed legal write frames; all entries read back RST_VAL after reset.

Optional Feature:
- Macro: SPI_SLV_AUTOINC_EN.
- Defined:
  - After a completed data byte with ss_n still low, the FSM returns to DATA with idx = idx + 1, wrapping modulo 2**ADDR_W.
  - The direction is kept from the address byte.
  - Reads preload the next register at the 8th rise; writes each pulse wr_evt_o.
  - An abort mid-byte drops only that byte.
- Not defined: DONE behaviour as above; extra bytes are ignored with no error.

Test Plan:
- Write frame, address byte 8'h83, data byte 8'h46 -> wr_evt_o pulses once with wr_addr_o=3, wr_data_o=8'h46; a following read of register 3 returns 8'h46.
- Read frame, address byte 8'h03 after the write above -> miso_o carries 0,1,1,0,0,0,1,0 (8'h46 LSB first); miso_oe_o is high for the data byte only and low after ss_n rises.
- Write 8'h53 to out-of-range address byte 8'hD3 (ADDR_W=4) -> frame_err_o pulses, no wr_evt_o, all registers unchanged.
- ss_n raised after 5 address bits -> frame_err_o pulses once, FSM back in IDLE; the next legal frame (8'h81, 8'hA5) writes register 1 = 8'hA5.
- prst_i asserted mid data byte of a write to register 2 -> all outputs 0 immediately; register 2 reads RST_VAL after reset is released.
- Burst with SPI_SLV_AUTOINC_EN: address byte 8'h8F, then data bytes 8'h11 and 8'h22 -> wr_evt_o for idx 15 then idx 0 (wrap); register 15 = 8'h11, register 0 = 8'h22.
